// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared state encoding, defaults and index helper for the UART TX arbiter
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

    localparam int DATA_SIZE_DEF    = 8;
    localparam int NUM_REQ_DEF      = 4;
    localparam int BUSY_TIMEOUT_DEF = 15;

    function automatic int wrap_idx(input int base, input int step, input int n);
        return (base + step) % n;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// rtl/uart_tx_arbiter_rr.sv - combinational round-robin pick starting one past the last grant
module rr_arbiter_uart
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [IW-1:0]      grant_idx,
    output logic               grant_vld
);

    always_comb begin
        logic [IW-1:0] sel;
        grant_oh  = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        sel       = '0;
        // Step k=NUM_REQ lands back on ptr itself, so the last grantee is considered last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            sel = IW'(wrap_idx(int'(ptr), k, NUM_REQ));
            if (!grant_vld && req[sel]) begin
                grant_vld     = 1'b1;
                grant_idx     = sel;
                grant_oh[sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART TX between byte requesters
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int DATA_SIZE    = DATA_SIZE_DEF,
    parameter int NUM_REQ      = NUM_REQ_DEF,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic                           CLK_FSM,
    input  logic                           RST_FSM,
    input  logic [NUM_REQ-1:0]             REQ_VLD,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   REQ_DATA,
    input  logic [NUM_REQ-1:0]             REQ_PAR_EN,
    output logic [NUM_REQ-1:0]             REQ_ACK,
    output logic [NUM_REQ-1:0]             REQ_DONE,
    output logic [DATA_SIZE-1:0]           TX_DATA,
    output logic                           TX_PAR_EN,
    output logic                           TX_DATA_VALID,
    input  logic                           TX_BUSY,
    output logic [$clog2(NUM_REQ)-1:0]     GRANT_ID,
    output logic                           ARB_BUSY,
    output logic                           TIMEOUT_ERR
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    arb_state_t state, state_next;

    logic [IW-1:0]        ptr, ptr_d;
    logic [TW-1:0]        timer, timer_d, timer_inc;
    logic [IW-1:0]        grant_id_d;
    logic [DATA_SIZE-1:0] data_d, pick_data;
    logic                 par_d;
    logic                 valid_d, arb_busy_d, err_d;
    logic [NUM_REQ-1:0]   ack_d, done_d;

    logic [NUM_REQ-1:0]   pick_oh;
    logic [IW-1:0]        pick_idx;
    logic                 pick_vld;
    logic                 launch_ok;

    rr_arbiter_uart #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .req       (REQ_VLD),
        .ptr       (ptr),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .grant_vld (pick_vld)
    );

    // A busy UART in IDLE is someone else's frame; just hold off the grant.
    assign launch_ok = pick_vld && !TX_BUSY;
    assign timer_inc = timer + TW'(1);

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) begin
                pick_data = REQ_DATA[i*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    always_ff @(posedge CLK_FSM or negedge RST_FSM) begin
        if (!RST_FSM) begin
            state         <= ST_IDLE;
            ptr           <= IW'(NUM_REQ - 1);
            timer         <= '0;
            GRANT_ID      <= '0;
            TX_DATA       <= '0;
            TX_PAR_EN     <= 1'b0;
            TX_DATA_VALID <= 1'b0;
            REQ_ACK       <= '0;
            REQ_DONE      <= '0;
            ARB_BUSY      <= 1'b0;
            TIMEOUT_ERR   <= 1'b0;
        end else begin
            state         <= state_next;
            ptr           <= ptr_d;
            timer         <= timer_d;
            GRANT_ID      <= grant_id_d;
            TX_DATA       <= data_d;
            TX_PAR_EN     <= par_d;
            TX_DATA_VALID <= valid_d;
            REQ_ACK       <= ack_d;
            REQ_DONE      <= done_d;
            ARB_BUSY      <= arb_busy_d;
            TIMEOUT_ERR   <= err_d;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (launch_ok) state_next = ST_LAUNCH;
            ST_LAUNCH:    state_next = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (TX_BUSY) begin
                    state_next = ST_WAIT_DONE;
                end else if (timer_inc == TW'(BUSY_TIMEOUT)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT_DONE: if (!TX_BUSY) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // Next values of every registered output; the pulses default low each cycle.
    always_comb begin
        ptr_d      = ptr;
        timer_d    = timer;
        grant_id_d = GRANT_ID;
        data_d     = TX_DATA;
        par_d      = TX_PAR_EN;
        valid_d    = 1'b0;
        ack_d      = '0;
        done_d     = '0;
        err_d      = 1'b0;
        arb_busy_d = (state_next != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (launch_ok) begin
                    grant_id_d = pick_idx;
                    data_d     = pick_data;
                    par_d      = REQ_PAR_EN[pick_idx];
                    valid_d    = 1'b1;
                    ack_d      = pick_oh;
                end
            end
            ST_LAUNCH: timer_d = '0;
            ST_WAIT_BUSY: begin
                if (!TX_BUSY) begin
                    timer_d = timer_inc;
                    if (timer_inc == TW'(BUSY_TIMEOUT)) begin
                        err_d   = 1'b1;
                        ptr_d   = GRANT_ID;
                        timer_d = '0;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (!TX_BUSY) begin
                    done_d = NUM_REQ'(1) << GRANT_ID;
                    ptr_d  = GRANT_ID;
                end
            end
            default: ;
        endcase
    end

endmodule
